// File: rtl/inst_queue_pkg.sv
// Shared types and helpers for the dual-issue instruction fetch queue.
// Optional bypass is selected by INST_QUEUE_BYPASS_EN.
package inst_queue_pkg;

    localparam int INST_W = 32;
    localparam int PC_W   = 32;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } iq_entry_t;

    // Pointer advance modulo the queue depth.
    function automatic int unsigned ptr_inc(input int unsigned ptr,
                                            input int unsigned n,
                                            input int unsigned depth);
        return (ptr + n) % depth;
    endfunction

endpackage

// File: rtl/inst_queue_if.sv
// Fetch-side and decode-side handshake bundle of the instruction queue.
interface inst_queue_if;

    logic        in_valid;
    logic        in_hi_valid;
    logic [63:0] in_data;
    logic [inst_queue_pkg::PC_W-1:0]   in_pc;
    logic        in_ready;

    logic        out_valid0;
    logic        out_valid1;
    logic [inst_queue_pkg::INST_W-1:0] out_inst0;
    logic [inst_queue_pkg::INST_W-1:0] out_inst1;
    logic [inst_queue_pkg::PC_W-1:0]   out_pc0;
    logic [inst_queue_pkg::PC_W-1:0]   out_pc1;
    logic [1:0]  out_pop;

    modport slave (
        input  in_valid, in_hi_valid, in_data, in_pc, out_pop,
        output in_ready, out_valid0, out_valid1, out_inst0, out_inst1, out_pc0, out_pc1
    );

    modport master (
        output in_valid, in_hi_valid, in_data, in_pc, out_pop,
        input  in_ready, out_valid0, out_valid1, out_inst0, out_inst1, out_pc0, out_pc1
    );

endinterface

// File: rtl/inst_queue_ptr_ctrl.sv
// Head/tail/occupancy bookkeeping for inst_queue: push acceptance, pop clamping, flush.
// INST_QUEUE_BYPASS_EN lets an empty queue hand incoming instructions straight to decode.
module iq_ptr_ctrl
    import inst_queue_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [1:0]       push_n,
    input  logic [1:0]       pop_req,
    output logic [PTR_W-1:0] head,
    output logic [PTR_W-1:0] tail,
    output logic [PTR_W:0]   count,
    output logic             in_ready,
    output logic             bypass,
    output logic [1:0]       wr_n,
    output logic [1:0]       wr_skip
);

    logic [1:0] push_acc;
    logic [1:0] avail;
    logic [1:0] pop_n;
    logic [1:0] q_pop;

    // Ready comes from registered occupancy only, so decode's pop never reaches fetch combinationally.
    always_comb begin
        in_ready = (DEPTH - int'(count)) >= 2;
        push_acc = (in_ready && !flush) ? push_n : 2'd0;
`ifdef INST_QUEUE_BYPASS_EN
        bypass   = (count == '0) && !flush;
`else
        bypass   = 1'b0;
`endif
        if (bypass)
            avail = push_acc;
        else if (count >= (PTR_W+1)'(2))
            avail = 2'd2;
        else
            avail = count[1:0];
        pop_n   = flush ? 2'd0 : ((pop_req > avail) ? avail : pop_req);
        wr_skip = bypass ? pop_n : 2'd0;
        q_pop   = bypass ? 2'd0 : pop_n;
        wr_n    = push_acc - wr_skip;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= PTR_W'(ptr_inc(32'(head), 32'(q_pop), DEPTH));
            tail  <= PTR_W'(ptr_inc(32'(tail), 32'(wr_n), DEPTH));
            count <= count + (PTR_W+1)'(wr_n) - (PTR_W+1)'(q_pop);
        end
    end

endmodule

// File: rtl/inst_queue.sv
// Dual-issue instruction fetch queue between the I-cache and decode.
// Optional zero-latency bypass on an empty queue: define INST_QUEUE_BYPASS_EN.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    inst_queue_if.slave    bus,
    output logic [PTR_W:0] count
);

    iq_entry_t        mem [DEPTH];
    iq_entry_t        in_lo;
    iq_entry_t        in_hi;
    iq_entry_t        first;
    iq_entry_t        slot0;
    iq_entry_t        slot1;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] head_p1;
    logic [PTR_W-1:0] tail_p1;
    logic [1:0]       push_n;
    logic [1:0]       wr_n;
    logic [1:0]       wr_skip;
    logic             in_ready;
    logic             bypass;

    assign push_n  = bus.in_valid ? (bus.in_hi_valid ? 2'd2 : 2'd1) : 2'd0;
    assign in_lo   = {bus.in_pc, bus.in_data[31:0]};
    assign in_hi   = {bus.in_pc + 32'd4, bus.in_data[63:32]};
    assign first   = (wr_skip == 2'd0) ? in_lo : in_hi;
    assign head_p1 = PTR_W'(ptr_inc(32'(head), 32'd1, DEPTH));
    assign tail_p1 = PTR_W'(ptr_inc(32'(tail), 32'd1, DEPTH));
    assign bus.in_ready = in_ready;

    iq_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .push_n   (push_n),
        .pop_req  (bus.out_pop),
        .head     (head),
        .tail     (tail),
        .count    (count),
        .in_ready (in_ready),
        .bypass   (bypass),
        .wr_n     (wr_n),
        .wr_skip  (wr_skip)
    );

    // Only instructions not already taken by decode through the bypass are stored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else begin
            if (wr_n != 2'd0)
                mem[tail] <= first;
            if (wr_n == 2'd2)
                mem[tail_p1] <= in_hi;
        end
    end

    always_comb begin
        slot0          = mem[head];
        slot1          = mem[head_p1];
        bus.out_valid0 = (count != '0);
        bus.out_valid1 = (count >= (PTR_W+1)'(2));
        if (bypass) begin
            slot0          = in_lo;
            slot1          = in_hi;
            bus.out_valid0 = bus.in_valid;
            bus.out_valid1 = bus.in_valid & bus.in_hi_valid;
        end
        bus.out_inst0 = slot0.inst;
        bus.out_pc0   = slot0.pc;
        bus.out_inst1 = slot1.inst;
        bus.out_pc1   = slot1.pc;
    end

endmodule
